// File: rtl/l1_dcache_assoc.sv
// l1_dcache_assoc: write-back, write-allocate N-way set-associative L1 data cache
// with tree pseudo-LRU replacement, whole-cache flush and saturating hit/miss counters.
module l1_dcache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                mem_byte_enable,
    input  logic [15:0]               mem_address,
    input  logic [15:0]               mem_wdata,
    output logic                      mem_resp,
    output logic [15:0]               mem_rdata,
    output logic [15:0]               pmem_address,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [16*LINE_WORDS-1:0]  pmem_wdata,
    input  logic [16*LINE_WORDS-1:0]  pmem_rdata,
    input  logic                      pmem_resp,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count
);
    localparam int LINE_BITS = 16 * LINE_WORDS;
    localparam int OFF_W     = $clog2(2 * LINE_WORDS);
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = 16 - OFF_W - IDX_W;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITEBACK  = 3'd1,
        ST_ALLOCATE   = 3'd2,
        ST_FLUSH_SCAN = 3'd3,
        ST_FLUSH_WB   = 3'd4
    } state_t;

    // PLRU bits point towards the least recently used side of each tree node.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] bits);
        logic [1:0] v;
        if (WAYS == 4) begin
            v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
        end else if (WAYS == 2) begin
            v = {1'b0, bits[0]};
        end else begin
            v = 2'b00;
        end
        return v[WAY_W-1:0];
    endfunction

    function automatic logic [2:0] plru_update(input logic [2:0] bits, input logic [WAY_W-1:0] way);
        logic [2:0] nb;
        logic [1:0] w2;
        nb = bits;
        w2 = 2'(way);
        if (WAYS == 4) begin
            nb[0] = ~w2[1];
            if (w2[1]) begin
                nb[2] = ~w2[0];
            end else begin
                nb[1] = ~w2[0];
            end
        end else if (WAYS == 2) begin
            nb[0] = ~w2[0];
        end else begin
            nb = 3'b000;
        end
        return nb;
    endfunction

    function automatic logic [LINE_BITS-1:0] merge_line(input logic [LINE_BITS-1:0] line,
                                                        input logic [OFF_W-1:0]     word,
                                                        input logic [1:0]           be,
                                                        input logic [15:0]          wd);
        logic [LINE_BITS-1:0] nl;
        nl = line;
        if (be[0]) nl[word*16 +: 8] = wd[7:0];
        if (be[1]) nl[word*16+8 +: 8] = wd[15:8];
        return nl;
    endfunction

    logic [LINE_BITS-1:0] r_data  [WAYS][SETS];
    logic [TAG_W-1:0]     r_tag   [WAYS][SETS];
    logic [WAYS-1:0]      r_valid [SETS];
    logic [WAYS-1:0]      r_dirty [SETS];
    logic [2:0]           r_plru  [SETS];

    state_t               r_state;
    logic [WAY_W-1:0]     r_victim;
    logic                 r_missed;
    logic [CNT_W-1:0]     r_hit_cnt;
    logic [CNT_W-1:0]     r_miss_cnt;
    logic                 r_pmem_read;
    logic                 r_pmem_write;
    logic [15:0]          r_pmem_addr;
    logic [LINE_BITS-1:0] r_pmem_wdata;
    logic                 r_flush_done;
    logic [IDX_W-1:0]     r_fset;
    logic [WAY_W-1:0]     r_fway;

    logic [TAG_W-1:0]     w_tag;
    logic [IDX_W-1:0]     w_idx;
    logic [OFF_W-1:0]     w_word;
    logic [WAYS-1:0]      w_hit_vec;
    logic                 w_hit;
    logic [WAY_W-1:0]     w_hit_way;
    logic [WAY_W-1:0]     w_victim;
    logic [LINE_BITS-1:0] w_hit_line;
    logic                 w_req;
    logic                 w_resp;
    logic                 w_hit_we;
    logic                 w_fill_we;
    logic                 w_last_pair;
    logic                 w_last_way;

    assign w_tag       = mem_address[15 -: TAG_W];
    assign w_idx       = mem_address[OFF_W +: IDX_W];
    assign w_word      = mem_address[OFF_W-1:0] >> 1;
    assign w_req       = mem_read | mem_write;
    assign w_hit       = |w_hit_vec;
    assign w_hit_line  = r_data[w_hit_way][w_idx];
    assign w_resp      = (r_state == ST_IDLE) & w_req & w_hit;
    assign w_hit_we    = w_resp & mem_write;
    assign w_fill_we   = (r_state == ST_ALLOCATE) & pmem_resp;
    assign w_last_way  = (r_fway == WAY_W'(WAYS - 1));
    assign w_last_pair = w_last_way & (r_fset == IDX_W'(SETS - 1));

    // Parallel tag compare across all ways of the addressed set.
    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit_vec[w] = 1'b1;
                w_hit_way    = WAY_W'(w);
            end else begin
                w_hit_vec[w] = 1'b0;
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the PLRU way.
    always_comb begin
        w_victim = plru_victim(r_plru[w_idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_victim = WAY_W'(w);
            end else begin
                w_victim = w_victim;
            end
        end
    end

    // Read data is only driven while the hit response is up.
    always_comb begin
        if (w_resp) begin
            mem_rdata = w_hit_line[w_word*16 +: 16];
        end else begin
            mem_rdata = 16'h0000;
        end
    end

    assign mem_resp     = w_resp;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_addr;
    assign pmem_wdata   = r_pmem_wdata;
    assign flush_done   = r_flush_done;
    assign hit_count    = r_hit_cnt;
    assign miss_count   = r_miss_cnt;

    // Line data and tag storage: fills replace the line, write hits merge bytes.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[r_victim][w_idx] <= pmem_rdata;
            r_tag[r_victim][w_idx]  <= w_tag;
        end else if (w_hit_we) begin
            r_data[w_hit_way][w_idx] <= merge_line(w_hit_line, w_word, mem_byte_enable, mem_wdata);
        end
    end

    // Controller FSM with line state, PLRU, counters and the memory-side handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_victim     <= '0;
            r_missed     <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= 16'h0000;
            r_pmem_wdata <= '0;
            r_flush_done <= 1'b0;
            r_fset       <= '0;
            r_fway       <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= 3'b000;
            end
        end else begin
            r_flush_done <= 1'b0;
            if (w_resp) begin
                r_missed <= 1'b0;
                if (!r_missed && (r_hit_cnt != {CNT_W{1'b1}})) begin
                    r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            r_plru[w_idx] <= plru_update(r_plru[w_idx], w_hit_way);
                            if (mem_write) begin
                                r_dirty[w_idx][w_hit_way] <= 1'b1;
                            end
                        end else begin
                            r_missed <= 1'b1;
                            r_victim <= w_victim;
                            if (r_miss_cnt != {CNT_W{1'b1}}) begin
                                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                            end
                            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                                r_state      <= ST_WRITEBACK;
                                r_pmem_write <= 1'b1;
                                r_pmem_addr  <= {r_tag[w_victim][w_idx], w_idx, {OFF_W{1'b0}}};
                                r_pmem_wdata <= r_data[w_victim][w_idx];
                            end else begin
                                r_state     <= ST_ALLOCATE;
                                r_pmem_read <= 1'b1;
                                r_pmem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            end
                        end
                    end else if (flush_req && !r_flush_done) begin
                        r_state <= ST_FLUSH_SCAN;
                        r_fset  <= '0;
                        r_fway  <= '0;
                    end
                end
                ST_WRITEBACK: begin
                    if (pmem_resp) begin
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_pmem_read  <= 1'b1;
                        r_pmem_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        r_state      <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (pmem_resp) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_plru[w_idx] <= plru_update(r_plru[w_idx], r_victim);
                        r_pmem_read   <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_FLUSH_SCAN: begin
                    if (r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway]) begin
                        r_state      <= ST_FLUSH_WB;
                        r_pmem_write <= 1'b1;
                        r_pmem_addr  <= {r_tag[r_fway][r_fset], r_fset, {OFF_W{1'b0}}};
                        r_pmem_wdata <= r_data[r_fway][r_fset];
                    end else begin
                        r_valid[r_fset][r_fway] <= 1'b0;
                        r_dirty[r_fset][r_fway] <= 1'b0;
                        if (w_last_pair) begin
                            r_state      <= ST_IDLE;
                            r_flush_done <= 1'b1;
                            for (int s = 0; s < SETS; s++) begin
                                r_plru[s] <= 3'b000;
                            end
                        end else if (w_last_way) begin
                            r_fway <= '0;
                            r_fset <= r_fset + IDX_W'(1);
                        end else begin
                            r_fway <= r_fway + WAY_W'(1);
                        end
                    end
                end
                ST_FLUSH_WB: begin
                    // Once clean, the rescan of this pair invalidates it and moves on.
                    if (pmem_resp) begin
                        r_pmem_write <= 1'b0;
                        r_dirty[r_fset][r_fway] <= 1'b0;
                        r_state <= ST_FLUSH_SCAN;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_dcache_assoc.sv
// Self-checking bench for l1_dcache_assoc: vector table against a flat reference memory,
// plus flush, reset-during-allocate and counter-saturation sequences.
module tb_l1_dcache_assoc;
    localparam int LW = 8;
    localparam int LB = 16 * LW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mem_read, mem_write;
    logic [1:0]    mem_byte_enable;
    logic [15:0]   mem_address, mem_wdata, mem_rdata, pmem_address;
    logic          mem_resp, pmem_read, pmem_write, pmem_resp, flush_req, flush_done;
    logic [LB-1:0] pmem_wdata, pmem_rdata;
    logic [15:0]   hit_count, miss_count;

    logic          s_read, s_resp, s_presp, s_pread, s_pwrite, s_fdone;
    logic [15:0]   s_rdata, s_paddr;
    logic [LB-1:0] s_pwdata, s_prdata;
    logic [3:0]    s_hits, s_miss;

    always #5 clk = ~clk;

    l1_dcache_assoc #(.WAYS(2), .SETS(8), .LINE_WORDS(LW), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .pmem_address(pmem_address),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .flush_req(flush_req),
        .flush_done(flush_done), .hit_count(hit_count), .miss_count(miss_count)
    );

    l1_dcache_assoc #(.WAYS(2), .SETS(8), .LINE_WORDS(LW), .CNT_W(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .mem_read(s_read), .mem_write(1'b0),
        .mem_byte_enable(2'b00), .mem_address(16'h0000), .mem_wdata(16'h0000),
        .mem_resp(s_resp), .mem_rdata(s_rdata), .pmem_address(s_paddr),
        .pmem_read(s_pread), .pmem_write(s_pwrite), .pmem_wdata(s_pwdata),
        .pmem_rdata(s_prdata), .pmem_resp(s_presp), .flush_req(1'b0),
        .flush_done(s_fdone), .hit_count(s_hits), .miss_count(s_miss)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        hit;
        int          wb;
        logic [15:0] wb_addr;
    } vec_t;

    vec_t          vt [0:18];
    logic [15:0]   ref_w  [logic [15:0]];
    logic [LB-1:0] line_m [logic [15:0]];
    logic [15:0]   exp_q [$];
    logic [16:0]   txq [$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            pm_wait = 0;
    logic [15:0]   pm_addr0;
    logic [15:0]   exp_hits = 16'h0000;
    logic [15:0]   exp_miss = 16'h0000;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return (a & 16'hFFFE) ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        logic [15:0] k;
        k = a & 16'hFFFE;
        if (ref_w.exists(k)) return ref_w[k];
        return pat(k);
    endfunction

    function automatic logic [LB-1:0] line_rd(input logic [15:0] la);
        logic [LB-1:0] l;
        if (line_m.exists(la)) return line_m[la];
        for (int i = 0; i < LW; i++) l[i*16 +: 16] = pat(la + 16'(2 * i));
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Memory-side responder: answers each line request on its third sampled cycle.
    task automatic pmem_step();
        if (pmem_read || pmem_write) begin
            if (pm_wait == 0) pm_addr0 = pmem_address;
            else check("pmem_addr_stable", 32'(pmem_address), 32'(pm_addr0));
            if (pm_wait == 2) begin
                txq.push_back({pmem_write, pmem_address});
                if (pmem_write) begin
                    for (int i = 0; i < LW; i++)
                        check("wb_data", 32'(pmem_wdata[i*16 +: 16]), 32'(ref_rd(pmem_address + 16'(2 * i))));
                    line_m[pmem_address] = pmem_wdata;
                end else begin
                    pmem_rdata = line_rd(pmem_address);
                end
                pmem_resp = 1'b1;
                pm_wait = 0;
            end else begin
                pm_wait++;
            end
        end else begin
            pm_wait = 0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc;
        logic        done;
        logic [15:0] old, exp;
        txq.delete();
        mem_read = v.rd; mem_write = v.wr; mem_byte_enable = v.be;
        mem_address = v.addr; mem_wdata = v.wd;
        if (v.wr) begin
            old = ref_rd(v.addr);
            ref_w[v.addr & 16'hFFFE] = {v.be[1] ? v.wd[15:8] : old[15:8], v.be[0] ? v.wd[7:0] : old[7:0]};
        end else begin
            exp_q.push_back(ref_rd(v.addr));
        end
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            #1;
            if (mem_resp) begin
                done = 1'b1;
                if (!v.wr) begin
                    exp = exp_q.pop_front();
                    check("rdata", 32'(mem_rdata), 32'(exp));
                end
            end else begin
                pmem_step();
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!done) cyc++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (v.hit) exp_hits = exp_hits + 16'd1;
        else exp_miss = exp_miss + 16'd1;
        check("completed", 32'(done), 32'd1);
        check("first_lookup_hit", 32'(cyc == 0), 32'(v.hit));
        check("txn_count", 32'(txq.size()), 32'(v.wb + (v.hit ? 0 : 1)));
        if (!v.hit && txq.size() > 0) check("fill_txn", 32'(txq[txq.size()-1]), 32'({1'b0, v.addr & 16'hFFF0}));
        if (v.wb > 0 && txq.size() > 0) check("wb_txn", 32'(txq[0]), 32'({1'b1, v.wb_addr}));
        check("hit_count", 32'(hit_count), 32'(exp_hits));
        check("miss_count", 32'(miss_count), 32'(exp_miss));
    endtask

    task automatic do_flush();
        int cyc, pulses, stray;
        txq.delete();
        flush_req = 1'b1;
        cyc = 0; pulses = 0; stray = 0;
        while (pulses == 0 && cyc < 300) begin
            #1;
            if (flush_done) pulses++;
            else pmem_step();
            @(negedge clk);
            pmem_resp = 1'b0;
            cyc++;
        end
        flush_req = 1'b0;
        repeat (30) begin
            #1;
            if (flush_done) pulses++;
            if (pmem_read || pmem_write) stray++;
            @(negedge clk);
        end
        check("flush_done_pulses", 32'(pulses), 32'd1);
        check("flush_stray_pmem", 32'(stray), 32'd0);
        check("flush_wb_count", 32'(txq.size()), 32'd2);
        if (txq.size() > 1) begin
            check("flush_wb0", 32'(txq[0]), 32'({1'b1, 16'h0020}));
            check("flush_wb1", 32'(txq[1]), 32'({1'b1, 16'h1230}));
        end
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
        mem_address = 16'h0000; mem_wdata = 16'h0000; pmem_rdata = '0; pmem_resp = 1'b0;
        flush_req = 1'b0; s_read = 1'b0; s_presp = 1'b0; s_prdata = '0;

        //            rd    wr    be     addr      wdata     hit   wb  wb_addr
        vt[0]  = '{1'b1, 1'b0, 2'b00, 16'h1234, 16'h0000, 1'b0, 0, 16'h0000};
        vt[1]  = '{1'b1, 1'b0, 2'b00, 16'h1234, 16'h0000, 1'b1, 0, 16'h0000};
        vt[2]  = '{1'b0, 1'b1, 2'b01, 16'h1234, 16'h00AB, 1'b1, 0, 16'h0000};
        vt[3]  = '{1'b1, 1'b0, 2'b00, 16'h1234, 16'h0000, 1'b1, 0, 16'h0000};
        vt[4]  = '{1'b1, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0, 0, 16'h0000};
        vt[5]  = '{1'b1, 1'b0, 2'b00, 16'h0090, 16'h0000, 1'b0, 0, 16'h0000};
        vt[6]  = '{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b1, 0, 16'h0000};
        vt[7]  = '{1'b1, 1'b0, 2'b00, 16'h0110, 16'h0000, 1'b0, 0, 16'h0000};
        vt[8]  = '{1'b1, 1'b0, 2'b00, 16'h0090, 16'h0000, 1'b0, 1, 16'h0010};
        vt[9]  = '{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0, 0, 16'h0000};
        vt[10] = '{1'b0, 1'b1, 2'b11, 16'h0020, 16'h2222, 1'b0, 0, 16'h0000};
        vt[11] = '{1'b0, 1'b1, 2'b10, 16'h1234, 16'h3333, 1'b1, 0, 16'h0000};
        vt[12] = '{1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b0, 0, 16'h0000};
        vt[13] = '{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0, 0, 16'h0000};
        vt[14] = '{1'b1, 1'b0, 2'b00, 16'h0090, 16'h0000, 1'b0, 0, 16'h0000};
        vt[15] = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 1'b0, 0, 16'h0000};
        vt[16] = '{1'b1, 1'b0, 2'b00, 16'h1234, 16'h0000, 1'b0, 0, 16'h0000};
        vt[17] = '{1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b0, 0, 16'h0000};
        vt[18] = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 1'b1, 0, 16'h0000};

        repeat (3) @(negedge clk);
        check("rst_mem_resp", 32'(mem_resp), 32'd0);
        check("rst_pmem_rw", 32'({pmem_read, pmem_write}), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_counters", 32'({hit_count, miss_count}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(vt[i]);
        do_flush();
        for (int i = 13; i < 18; i++) run_vec(vt[i]);

        // A stray pmem_resp while idle must not touch the cache.
        mem_address = 16'h0020; pmem_rdata = {LB{1'b1}}; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        run_vec(vt[18]);

        // Reset while a fill is outstanding.
        mem_read = 1'b1; mem_address = 16'h0500;
        cyc = 0;
        while (!pmem_read && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("alloc_started", 32'(pmem_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_async_counters", 32'({hit_count, miss_count}), 32'd0);
        check("rst_async_mem_resp", 32'(mem_resp), 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_hits = 16'h0000; exp_miss = 16'h0000; pm_wait = 0; exp_q.delete();
        @(negedge clk);
        vt[0] = '{1'b1, 1'b0, 2'b00, 16'h0500, 16'h0000, 1'b0, 0, 16'h0000};
        run_vec(vt[0]);
        vt[0].hit = 1'b1;
        run_vec(vt[0]);

        // Saturation on the 4-bit-counter instance: one miss then 20 back-to-back hits.
        s_read = 1'b1;
        cyc = 0;
        #1;
        while (!s_resp && cyc < 50) begin
            s_presp = s_pread;
            @(negedge clk);
            s_presp = 1'b0;
            #1;
            cyc++;
        end
        check("sat_fill_done", 32'(s_resp), 32'd1);
        @(negedge clk);
        check("sat_after_fill", 32'(s_hits), 32'd0);
        repeat (14) @(negedge clk);
        check("sat_14_hits", 32'(s_hits), 32'd14);
        repeat (6) @(negedge clk);
        check("sat_20_hits", 32'(s_hits), 32'd15);
        s_read = 1'b0;
        check("sat_miss_count", 32'(s_miss), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/l1_dcache_assoc.md
# l1_dcache_assoc

Parametrised, write-back, write-allocate, N-way set-associative L1 data cache between the CPU memory port and the physical-memory line bus. It generalises the direct-mapped L1 data cache to configurable ways, sets and line size, with pseudo-LRU replacement. It adds a whole-cache flush and saturating hit/miss counters. Data and tag arrays are flop-based with asynchronous read and synchronous write.

## Interface
- WAYS, 2, associativity; legal values 1, 2, 4
- SETS, 8, sets; power of two, at least 2
- LINE_WORDS, 8, 16-bit words per line; power of two; LINE_BITS = 16*LINE_WORDS
- CNT_W, 16, counter width
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_read / mem_write  in  1  CPU request; held stable until mem_resp
- mem_byte_enable  in  2  write byte mask (bit1 = high byte)
- mem_address  in  16  byte address; offset = log2(2*LINE_WORDS) bits, index = log2(SETS) bits, tag = remainder
- mem_wdata  in  16  write data
- mem_resp  out  1  request complete, one cycle
- mem_rdata  out  16  read word, valid while mem_resp is high
- pmem_address  out  16  line-aligned address; offset bits are 0
- pmem_read / pmem_write  out  1  line request; held until pmem_resp
- pmem_wdata  out  LINE_BITS  victim line
- pmem_rdata  in  LINE_BITS  fill line
- pmem_resp  in  1  line transfer done
- flush_req  in  1  level; held until flush_done
- flush_done  out  1  one-cycle pulse
- hit_count / miss_count  out  CNT_W  saturating counters

## Operation
- FSM states: IDLE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
- IDLE with mem_read or mem_write:
  - Tag compare runs across all ways, combinationally.
  - If both mem_read and mem_write are high, the request is a write.
- Hit handling:
  - mem_resp is asserted in the same cycle.
  - Read: mem_rdata is the addressed word.
  - Write: merge the bytes selected by mem_byte_enable and set dirty.
  - Update PLRU for the hit way.
- Miss handling:
  - Victim = lowest-index invalid way; if all ways are valid, the PLRU way.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - pmem_write = 1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim line.
  - On pmem_resp, clear dirty and go to ALLOCATE.
- ALLOCATE:
  - pmem_read = 1; pmem_address = {tag, index, 0}.
  - On pmem_resp, write the line, set valid, clear dirty, go to IDLE.
  - The request then hits and completes in IDLE.
- PLRU replacement:
  - WAYS=1: none.
  - WAYS=2: one bit per set pointing to the LRU way; an access to way w sets it to ~w.
  - WAYS=4: 3-bit tree per set. b0 selects the half, b1 selects between ways 0/1, b2 between ways 2/3. Each bit points away from the accessed way.
  - A fill updates PLRU like a hit.
- Flush:
  - Accepted in IDLE only when mem_read and mem_write are both low; a CPU request has priority.
  - FLUSH_SCAN visits (set, way) pairs in order: set-major, way ascending, one pair per cycle.
  - A dirty valid line goes to FLUSH_WB, which writes it back with the same handshake as WRITEBACK, then resumes the scan.
  - Each visited line is invalidated.
  - After the last pair: flush_done pulses for 1 cycle, PLRU is cleared, return to IDLE.
- Counters:
  - hit_count increments on a mem_resp only for a request that hit on its first lookup.
  - miss_count increments once per miss, when leaving IDLE.
  - Both saturate at all-ones.

## Timing
- Reset (asynchronous):
  - All valid, dirty and PLRU bits cleared; counters 0; FSM to IDLE.
  - mem_resp, pmem_read, pmem_write and flush_done all 0.
  - An in-flight pmem transaction is abandoned; pmem_read/pmem_write drop without waiting for a clock.
- Hit latency: 0 cycles; mem_resp is combinational from the request while in IDLE.
- Clean-miss latency: ALLOCATE cycles + 1 IDLE cycle.
- Dirty-miss latency: adds the WRITEBACK cycles.
- pmem_address and pmem_wdata are stable for the whole time pmem_read/pmem_write is high.
- A pmem_resp arriving outside WRITEBACK, ALLOCATE or FLUSH_WB is ignored.
- A clean flush takes SETS*WAYS + 1 cycles; each dirty line adds its writeback handshake.
- flush_req low in IDLE: no flush.
- flush_req sampled high in the flush_done cycle: this does not start a second flush.

## Test plan
- Configuration: WAYS=2, SETS=8, LINE_WORDS=8, so index = addr[6:4].
- Cold read: after reset, read 0x1234 -> pmem_read at 0x1230. After pmem_resp, mem_resp with rdata = word 2 of the line. miss_count=1, hit_count=0. Repeat read -> mem_resp same cycle, hit_count=1.
- Byte write: write 0x00AB with mask 01 to 0x1234 -> the following read returns {old high byte, 0xAB}; no pmem traffic.
- Replacement: write 0x0010, read 0x0090, read 0x0010, read 0x0110 -> 0x0090 evicted with no pmem_write. Then read 0x0090 -> pmem_write at 0x0010 with the dirty data, then pmem_read at 0x0090.
- Flush: with 2 dirty and 3 clean valid lines, assert flush_req -> exactly 2 pmem_write transactions, one flush_done pulse. A later read of any of those addresses misses.
- Reset mid-allocate: drop reset_n while pmem_read=1 -> pmem_read is 0 immediately, counters 0. A re-read of the same address misses.
- Saturation: CNT_W=4, 20 hits -> hit_count = 15 and holds.
